// File: rtl/ebv1_rd_pkg.sv
// Shared geometry defaults for the line-buffer read side.
package ebv1_rd_pkg;
  localparam int CHAR_WIDTH_DEF = 11;
  localparam int LINE_WIDTH_DEF = 3;
endpackage

// File: rtl/read_ptr_counters.sv
// Read character/line counters; one-cycle update, en gates all movement.
// newline takes priority over incr; the caller decides legality.
module read_ptr_counters
  import ebv1_rd_pkg::*;
#(
  parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  incr,
  input  logic                  newline,
  output logic [CHAR_WIDTH-1:0] rd_char,
  output logic [LINE_WIDTH-1:0] rd_line
);

  logic [CHAR_WIDTH-1:0] rd_char_q, rd_char_d;
  logic [LINE_WIDTH-1:0] rd_line_q, rd_line_d;

  always_comb begin
    rd_char_d = rd_char_q;
    rd_line_d = rd_line_q;
    if (en) begin
      if (newline) begin
        rd_char_d = '0;
        rd_line_d = rd_line_q + 1'b1;
      end else if (incr) begin
        rd_char_d = rd_char_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_char_q <= '0;
      rd_line_q <= '0;
    end else begin
      rd_char_q <= rd_char_d;
      rd_line_q <= rd_line_d;
    end
  end

  assign rd_char = rd_char_q;
  assign rd_line = rd_line_q;

endmodule

// File: rtl/read_logic_storage_mp.sv
// Per-line commit tracking and read pointer for a multi-line buffer; status is
// combinational from registers, state moves one cycle after a request, illegal requests pulse an error.
module read_logic_storage_mp
  import ebv1_rd_pkg::*;
#(
  parameter int CHAR_WIDTH = CHAR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int ADDR_WIDTH = CHAR_WIDTH + LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_char_incr,
  input  logic                  rd_newline,
  input  logic                  wr_commit,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic [CHAR_WIDTH-1:0] wr_last_char,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [LINE_WIDTH-1:0] rd_line,
  output logic                  line_avail,
  output logic                  tlast_flag,
  output logic [LINE_WIDTH:0]   lines_used,
  output logic                  full,
  output logic                  empty,
  output logic                  rd_err,
  output logic                  wr_err
);

  localparam int NLINES = 1 << LINE_WIDTH;
  localparam logic [LINE_WIDTH:0] USED_MAX = {1'b1, {LINE_WIDTH{1'b0}}};

  logic [NLINES-1:0]     valid_q, valid_d;
  logic [CHAR_WIDTH-1:0] end_ptr_q [NLINES];
  logic [CHAR_WIDTH-1:0] end_ptr_d [NLINES];
  logic [LINE_WIDTH:0]   lines_used_q, lines_used_d;
  logic                  rd_err_q, rd_err_d;
  logic                  wr_err_q, wr_err_d;

  logic [CHAR_WIDTH-1:0] rd_char;
  logic                  nl_ok, inc_ok, wr_ok;

  assign line_avail = valid_q[rd_line];
  assign tlast_flag = line_avail && (rd_char == end_ptr_q[rd_line]);

  // A line being released still reads as valid, so a same-cycle commit to it is rejected.
  assign nl_ok  = rd_newline && line_avail;
  assign inc_ok = rd_char_incr && !rd_newline && line_avail && !tlast_flag;
  assign wr_ok  = wr_commit && !valid_q[wr_line];

  read_ptr_counters #(
    .CHAR_WIDTH (CHAR_WIDTH),
    .LINE_WIDTH (LINE_WIDTH)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .en      (nl_ok | inc_ok),
    .incr    (inc_ok),
    .newline (nl_ok),
    .rd_char (rd_char),
    .rd_line (rd_line)
  );

  always_comb begin
    valid_d   = valid_q;
    end_ptr_d = end_ptr_q;
    if (nl_ok) valid_d[rd_line] = 1'b0;
    if (wr_ok) begin
      valid_d[wr_line]   = 1'b1;
      end_ptr_d[wr_line] = wr_last_char;
    end
    lines_used_d = lines_used_q + (LINE_WIDTH+1)'(wr_ok) - (LINE_WIDTH+1)'(nl_ok);
    rd_err_d = (rd_newline && !line_avail) ||
               (rd_char_incr && !rd_newline && (!line_avail || tlast_flag));
    wr_err_d = wr_commit && valid_q[wr_line];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      lines_used_q <= '0;
      rd_err_q     <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      lines_used_q <= lines_used_d;
      rd_err_q     <= rd_err_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // End pointers are only meaningful behind a set valid bit, so they skip reset.
  always_ff @(posedge clk) begin
    if (rst) end_ptr_q <= end_ptr_d;
  end

  assign rd_ptr     = {rd_line, rd_char};
  assign lines_used = lines_used_q;
  assign full       = (lines_used_q == USED_MAX);
  assign empty      = (lines_used_q == '0);
  assign rd_err     = rd_err_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_read_logic_storage_mp.sv
// Directed bench for read_logic_storage_mp at default geometry.
module tb_read_logic_storage_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_char_incr, rd_newline, wr_commit;
  logic [2:0]  wr_line;
  logic [10:0] wr_last_char;
  logic [13:0] rd_ptr;
  logic [2:0]  rd_line;
  logic        line_avail, tlast_flag, full, empty, rd_err, wr_err;
  logic [3:0]  lines_used;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  read_logic_storage_mp dut (
    .clk          (clk),
    .rst          (rst),
    .rd_char_incr (rd_char_incr),
    .rd_newline   (rd_newline),
    .wr_commit    (wr_commit),
    .wr_line      (wr_line),
    .wr_last_char (wr_last_char),
    .rd_ptr       (rd_ptr),
    .rd_line      (rd_line),
    .line_avail   (line_avail),
    .tlast_flag   (tlast_flag),
    .lines_used   (lines_used),
    .full         (full),
    .empty        (empty),
    .rd_err       (rd_err),
    .wr_err       (wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; rd_char_incr = 1'b0; rd_newline = 1'b0;
    wr_commit = 1'b0; wr_line = '0; wr_last_char = '0;
  endtask

  // Inputs apply across one rising edge, then return to idle; sampling is 1ns after the edge.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic commit(input logic [2:0] ln, input logic [10:0] last);
    wr_commit = 1'b1; wr_line = ln; wr_last_char = last;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ptr"},   32'(rd_ptr), 0);
    chk({tag, "_line"},  32'(rd_line), 0);
    chk({tag, "_avail"}, 32'(line_avail), 0);
    chk({tag, "_tlast"}, 32'(tlast_flag), 0);
    chk({tag, "_used"},  32'(lines_used), 0);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_rderr"}, 32'(rd_err), 0);
    chk({tag, "_wrerr"}, 32'(wr_err), 0);
  endtask

  initial begin
    idle();
    @(negedge clk);
    // Reset with a commit attempt that must be ignored.
    rst = 1'b0; wr_commit = 1'b1; wr_line = 3'd0; wr_last_char = 11'd3;
    tick();
    chk_reset_state("rst0");

    // Increment with nothing committed.
    rd_char_incr = 1'b1; tick();
    chk("inc_empty_ptr", 32'(rd_ptr), 0);
    chk("inc_empty_err", 32'(rd_err), 1);
    chk("inc_empty_empty", 32'(empty), 1);
    tick();
    chk("rderr_pulse_clears", 32'(rd_err), 0);

    // Single line, last char 3.
    commit(3'd0, 11'd3);
    chk("c0_avail", 32'(line_avail), 1);
    chk("c0_used", 32'(lines_used), 1);
    chk("c0_tlast", 32'(tlast_flag), 0);
    chk("c0_empty", 32'(empty), 0);
    for (int i = 0; i < 3; i++) begin rd_char_incr = 1'b1; tick(); end
    chk("inc3_ptr", 32'(rd_ptr), 3);
    chk("inc3_tlast", 32'(tlast_flag), 1);
    chk("inc3_noerr", 32'(rd_err), 0);
    rd_char_incr = 1'b1; tick();
    chk("inc4_err", 32'(rd_err), 1);
    chk("inc4_ptr", 32'(rd_ptr), 3);
    rd_newline = 1'b1; tick();
    chk("nl_ptr", 32'(rd_ptr), 32'h800);
    chk("nl_used", 32'(lines_used), 0);
    chk("nl_avail", 32'(line_avail), 0);
    chk("nl_noerr", 32'(rd_err), 0);
    rd_newline = 1'b1; tick();
    chk("nl_unavail_err", 32'(rd_err), 1);
    chk("nl_unavail_ptr", 32'(rd_ptr), 32'h800);

    // Fill all eight lines; line i ends at char i.
    do_reset();
    for (int i = 0; i < 8; i++) commit(3'(i), 11'(i));
    chk("fill_full", 32'(full), 1);
    chk("fill_used", 32'(lines_used), 8);
    chk("fill_tlast_len1", 32'(tlast_flag), 1);
    commit(3'd2, 11'd9);
    chk("recommit_wrerr", 32'(wr_err), 1);
    chk("recommit_used", 32'(lines_used), 8);
    tick();
    chk("wrerr_pulse_clears", 32'(wr_err), 0);

    // Drain all eight lines, wrapping the line index.
    rd_newline = 1'b1; tick();
    chk("drain1_used", 32'(lines_used), 7);
    chk("drain1_full", 32'(full), 0);
    chk("drain1_line", 32'(rd_line), 1);
    chk("drain1_tlast", 32'(tlast_flag), 0);
    rd_char_incr = 1'b1; tick();
    chk("line1_tlast", 32'(tlast_flag), 1);
    for (int i = 0; i < 7; i++) begin rd_newline = 1'b1; tick(); end
    chk("wrap_line", 32'(rd_line), 0);
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_avail0", 32'(line_avail), 0);
    commit(3'd0, 11'd1);
    chk("wrap_avail1", 32'(line_avail), 1);
    chk("wrap_ptr", 32'(rd_ptr), 0);

    // Simultaneous newline and commit.
    do_reset();
    commit(3'd0, 11'd5);
    commit(3'd1, 11'd2);
    rd_newline = 1'b1; wr_commit = 1'b1; wr_line = 3'd0; wr_last_char = 11'd4;
    tick();
    chk("sim_wrerr", 32'(wr_err), 1);
    chk("sim_used", 32'(lines_used), 1);
    chk("sim_line", 32'(rd_line), 1);
    chk("sim_rderr", 32'(rd_err), 0);
    rd_newline = 1'b1; rd_char_incr = 1'b1; wr_commit = 1'b1; wr_line = 3'd0; wr_last_char = 11'd4;
    tick();
    chk("both_rderr", 32'(rd_err), 0);
    chk("both_wrerr", 32'(wr_err), 0);
    chk("both_used", 32'(lines_used), 1);
    chk("both_ptr", 32'(rd_ptr), 32'h1000);
    chk("both_avail", 32'(line_avail), 0);

    // Mid-operation reset.
    do_reset();
    commit(3'd0, 11'd0);
    commit(3'd1, 11'd7);
    commit(3'd2, 11'd7);
    rd_newline = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin rd_char_incr = 1'b1; tick(); end
    chk("pre_rst_ptr", 32'(rd_ptr), 32'h805);
    chk("pre_rst_used", 32'(lines_used), 2);
    rd_char_incr = 1'b1; wr_commit = 1'b1; wr_line = 3'd3; rst = 1'b0;
    @(posedge clk); #1;
    idle();
    chk_reset_state("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/read_logic_storage_mp.md
READ_LOGIC_STORAGE_MP -- requirements
Module: read_logic_storage_mp

Interface
REQ-001 Parameter CHAR_WIDTH, default 11, width of the character (byte) index within one line.
REQ-002 Parameter LINE_WIDTH, default 3, width of the line index; the block tracks 2**LINE_WIDTH lines.
REQ-003 Parameter ADDR_WIDTH, default CHAR_WIDTH+LINE_WIDTH, read pointer width; no other value is legal.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 rd_char_incr  in  1  advance read character index by one.
REQ-007 rd_newline  in  1  release current line, move to next line.
REQ-008 wr_commit  in  1  write side publishes one complete line.
REQ-009 wr_line  in  LINE_WIDTH  line being committed.
REQ-010 wr_last_char  in  CHAR_WIDTH  index of the final character of the committed line.
REQ-011 rd_ptr  out  ADDR_WIDTH  {rd_line, rd_char} buffer read address.
REQ-012 rd_line  out  LINE_WIDTH  current read line index.
REQ-013 line_avail  out  1  current read line is committed and unreleased.
REQ-014 tlast_flag  out  1  rd_ptr addresses the last character of an available line.
REQ-015 lines_used  out  LINE_WIDTH+1  count of committed, unreleased lines.
REQ-016 full  out  1  lines_used == 2**LINE_WIDTH.
REQ-017 empty  out  1  lines_used == 0.
REQ-018 rd_err  out  1  one-cycle pulse: illegal read request ignored.
REQ-019 wr_err  out  1  one-cycle pulse: illegal commit ignored.

Function
REQ-020 Per line the block SHALL hold valid[i] (1 bit) and end_ptr[i] (CHAR_WIDTH bits).
REQ-021 Accepted commit (wr_commit=1, valid[wr_line]=0): next cycle valid[wr_line]=1, end_ptr[wr_line]=wr_last_char, lines_used+1.
REQ-022 Commit to a line with valid=1 SHALL be ignored (no state change) and wr_err=1 next cycle.
REQ-023 line_avail SHALL equal valid[rd_line]; tlast_flag SHALL equal valid[rd_line] AND rd_char==end_ptr[rd_line]; both combinational from registers, zero latency.
REQ-024 Accepted rd_newline (line_avail=1): next cycle valid[rd_line]=0, rd_char=0, rd_line=rd_line+1 modulo 2**LINE_WIDTH, lines_used-1.
REQ-025 rd_newline with line_avail=0 SHALL be ignored and rd_err=1 next cycle.
REQ-026 Accepted rd_char_incr (line_avail=1, tlast_flag=0, rd_newline=0): rd_char+1 next cycle.
REQ-027 rd_char_incr with line_avail=0 or tlast_flag=1 (and rd_newline=0) SHALL be ignored and rd_err=1 next cycle; rd_char never wraps.
REQ-028 rd_char_incr and rd_newline together: rd_newline rules apply, rd_char_incr ignored without error.
REQ-029 Accepted commit and accepted newline in the same cycle: both take effect, lines_used unchanged; commit to the line being released is rejected per REQ-022 (its valid is still 1).
REQ-030 full and empty SHALL be combinational from lines_used; lines_used never exceeds 2**LINE_WIDTH nor goes below 0.

Reset
REQ-031 With rst=0 at a clock edge: rd_char=0, rd_line=0, all valid=0, lines_used=0, rd_err=0, wr_err=0; hence rd_ptr=0, line_avail=0, tlast_flag=0, full=0, empty=1.
REQ-032 end_ptr contents SHALL not require reset; reset mid-operation discards all committed lines and in-progress reads.
REQ-033 All inputs SHALL be ignored during the reset cycle.

Structure
REQ-034 Shared package ebv1_rd_pkg SHALL hold default CHAR_WIDTH/LINE_WIDTH constants.
REQ-035 One sub-module read_ptr_counters (parametrised char/line counter with increment, newline and enable inputs) SHALL generate rd_char/rd_line; valid/end_ptr array and occupancy logic live in the top.

Verification (defaults)
REQ-036 Reset, then rd_char_incr=1 -> rd_ptr stays 0, rd_err pulses, empty=1.
REQ-037 Commit line 0 last_char=3, 3 incr -> rd_ptr=3, tlast_flag=1; 4th incr -> rd_err, rd_ptr=3; rd_newline -> rd_ptr=0x800, lines_used=0.
REQ-038 Commit lines 0..7 -> full=1, lines_used=8; re-commit line 2 -> wr_err, lines_used=8.
REQ-039 Read through 8 lines then commit line 0 -> rd_line wraps to 0, line_avail=1.
REQ-040 Lines 0,1 committed; same cycle rd_newline on line 0 and commit line 0 -> wr_err, lines_used=1, rd_line=1; rd_char_incr with rd_newline -> incr ignored, no rd_err.
REQ-041 Three lines committed, rd_ptr=0x805, assert rst=0 one cycle -> all outputs at REQ-031 values.
